// File: rtl/fir_folded_mac.sv
// Time-multiplexed FIR filter: LANES multipliers sweep NTAPS taps over NTAPS/LANES beats,
// with valid/ready on both sides, a run-time coefficient port and round/saturate output.
module fir_folded_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NTAPS     = 100,
    parameter int LANES     = 2,
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(NTAPS),
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_W-1:0]   data_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [OUT_W-1:0]    data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sat,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       coef_err
);

    localparam int BEATS  = NTAPS / LANES;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW     = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = ACC_W + $clog2(LANES) + 1;
    // Wide enough to hold both the lane sum and the saturation limits without wrap.
    localparam int WW     = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
    localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    localparam logic signed [WW-1:0] RND     = (OUT_SHIFT > 0) ? (WW'(1) <<< RND_SH) : WW'(0);
    localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StDrain, StOut} state_t;

    state_t                    state_q, state_d;
    logic [BW-1:0]             beat_q;
    logic signed [DATA_W-1:0]  x_q [NTAPS];
    logic signed [COEF_W-1:0]  h_q [NTAPS];
    logic signed [PROD_W-1:0]  prod_q [LANES];
    logic signed [ACC_W-1:0]   acc_q [LANES];
    logic                      prod_vld_q, prod_first_q;
    logic signed [OUT_W-1:0]   data_out_q;
    logic                      out_sat_q, coef_err_q;

    logic                      accept, last_beat, coef_ok, final_step;
    logic [IW-1:0]             lane_idx [LANES];
    logic signed [DATA_W-1:0]  mul_x [LANES];
    logic signed [COEF_W-1:0]  mul_h [LANES];
    logic signed [SUM_W-1:0]   sum;
    logic signed [WW-1:0]      rounded, shifted;
    logic signed [OUT_W-1:0]   sat_val;
    logic                      sat_flag;

    assign accept     = in_valid && in_ready;
    assign last_beat  = (beat_q == BW'(BEATS - 1));
    assign coef_ok    = (state_q == StIdle) && ({1'b0, coef_addr} < (IW + 1)'(NTAPS));
    // The DRAIN cycle that sees no pending products is the one that produces the result.
    assign final_step = (state_q == StDrain) && !prod_vld_q;
    assign data_out   = data_out_q;
    assign out_sat    = out_sat_q;
    assign coef_err   = coef_err_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StOut);
        unique case (state_q)
            StIdle:  if (accept) state_d = StMac;
            StMac:   if (last_beat) state_d = StDrain;
            StDrain: if (!prod_vld_q) state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Per-lane operand selection: lane l owns taps l*BEATS .. l*BEATS+BEATS-1.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = IW'(l * BEATS) + IW'(beat_q);
            mul_x[l]    = x_q[lane_idx[l]];
            mul_h[l]    = h_q[lane_idx[l]];
        end
    end

    // Delay line, beat counter, product pipeline and lane accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= '0;
                acc_q[l]  <= '0;
            end
            beat_q       <= '0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
        end else begin
            if (accept) begin
                x_q[0] <= data_in;
                for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
                beat_q <= '0;
            end else if (state_q == StMac && !last_beat) begin
                beat_q <= beat_q + 1'b1;
            end
            prod_vld_q   <= (state_q == StMac);
            prod_first_q <= (state_q == StMac) && (beat_q == '0);
            if (state_q == StMac) begin
                for (int l = 0; l < LANES; l++) begin
                    prod_q[l] <= PROD_W'(mul_x[l]) * PROD_W'(mul_h[l]);
                end
            end
            // First product of a sample overwrites, so no clear cycle is needed.
            if (prod_vld_q) begin
                for (int l = 0; l < LANES; l++) begin
                    acc_q[l] <= prod_first_q ? ACC_W'(prod_q[l]) : acc_q[l] + ACC_W'(prod_q[l]);
                end
            end
        end
    end

    // Lane reduction, round half up, arithmetic shift and saturation.
    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++) sum = sum + SUM_W'(acc_q[l]);
        rounded  = WW'(sum) + RND;
        shifted  = rounded >>> OUT_SHIFT;
        sat_flag = 1'b0;
        sat_val  = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val  = {1'b0, {(OUT_W-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_val  = {1'b1, {(OUT_W-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    // Result register, held through OUT until the downstream handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
            out_sat_q  <= 1'b0;
        end else if (final_step) begin
            data_out_q <= sat_val;
            out_sat_q  <= sat_flag;
        end
    end

    // Coefficient bank; writes outside IDLE or past the last tap are dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) h_q[k] <= '0;
            coef_err_q <= 1'b0;
        end else begin
            coef_err_q <= coef_we && !coef_ok;
            if (coef_we && coef_ok) h_q[coef_addr] <= coef_wdata;
        end
    end

endmodule

// File: tb/tb_fir_folded_mac.sv
// Directed bench for fir_folded_mac: four instances share stimulus, one is observed at a time.
module tb_fir_folded_mac;

    logic               clk = 1'b0;
    logic               rst, in_valid, out_ready, coef_we;
    logic signed [15:0] data_in;
    logic [6:0]         coef_addr;
    logic signed [15:0] coef_wdata;

    logic [3:0]         rdy, vld, sat, err;
    logic [31:0]        dout0, dout1, dout2, dout3;

    logic [1:0]         sel;
    logic               o_rdy, o_vld, o_sat, o_err;
    logic [31:0]        o_dout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_folded_mac #(.NTAPS(100), .LANES(2), .OUT_SHIFT(0)) u_l2_s0 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy[0]),
        .data_out(dout0), .out_valid(vld[0]), .out_ready(out_ready), .out_sat(sat[0]),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(err[0]));

    fir_folded_mac #(.NTAPS(100), .LANES(2), .OUT_SHIFT(15)) u_l2_s15 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy[1]),
        .data_out(dout1), .out_valid(vld[1]), .out_ready(out_ready), .out_sat(sat[1]),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(err[1]));

    fir_folded_mac #(.NTAPS(100), .LANES(1), .OUT_SHIFT(0)) u_l1_s0 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy[2]),
        .data_out(dout2), .out_valid(vld[2]), .out_ready(out_ready), .out_sat(sat[2]),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(err[2]));

    fir_folded_mac #(.NTAPS(100), .LANES(4), .OUT_SHIFT(0)) u_l4_s0 (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy[3]),
        .data_out(dout3), .out_valid(vld[3]), .out_ready(out_ready), .out_sat(sat[3]),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(err[3]));

    // Route the observed instance's outputs to the o_* probes.
    always_comb begin
        o_rdy = rdy[sel];
        o_vld = vld[sel];
        o_sat = sat[sel];
        o_err = err[sel];
        case (sel)
            2'd0:    o_dout = dout0;
            2'd1:    o_dout = dout1;
            2'd2:    o_dout = dout2;
            default: o_dout = dout3;
        endcase
    end

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we = 1'b1; coef_addr = 7'(a); coef_wdata = 16'(v);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Starts at the negedge right after the accepting edge; lat = edges until out_valid.
    task automatic wait_out(output logic [31:0] d, output logic s, output int lat);
        lat = 0;
        while (!o_vld && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (!o_vld) begin
            n_bad++;
            $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", o_vld, lat);
        end
        d = o_dout;
        s = o_sat;
    endtask

    task automatic send(input int v, output logic [31:0] d, output logic s, output int lat);
        int w = 0;
        data_in = 16'(v); in_valid = 1'b1;
        while (!o_rdy && w < 400) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (!o_rdy) begin
            n_bad++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", o_rdy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(d, s, lat);
    endtask

    task automatic test_reset();
        sel = 2'd0;
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        data_in = '0; coef_addr = '0; coef_wdata = '0;
        @(negedge clk);
        n_cmp++; if (o_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", o_rdy); end
        n_cmp++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", o_vld); end
        n_cmp++; if (o_dout !== 32'd0) begin n_bad++; $display("FAIL rst_data_out: got %h want 0", o_dout); end
        n_cmp++; if (o_sat !== 1'b0) begin n_bad++; $display("FAIL rst_out_sat: got %b want 0", o_sat); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL rst_coef_err: got %b want 0", o_err); end
        rst = 1'b0;
        #1;
        n_cmp++; if (o_rdy !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready: got %b want 1", o_rdy); end
        @(negedge clk);
    endtask

    task automatic test_impulse(input logic [1:0] s, input int beats);
        logic [31:0] d; logic sv; int lat; int exp;
        sel = s;
        do_reset();
        for (int k = 0; k < 100; k++) write_coef(k, k + 1);
        for (int n = 0; n <= 100; n++) begin
            send((n == 0) ? 1 : 0, d, sv, lat);
            exp = (n < 100) ? n + 1 : 0;
            n_cmp++;
            if (d !== 32'(exp)) begin
                n_bad++;
                $display("FAIL impulse_l%0d[%0d]: got %0d want %0d", s, n, $signed(d), exp);
            end
            n_cmp++;
            if (lat != beats + 2) begin
                n_bad++;
                $display("FAIL latency_l%0d[%0d]: got %0d want %0d", s, n, lat, beats + 2);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] d; logic sv; int lat;
        sel = 2'd1;
        do_reset();
        write_coef(0, 16'h4000);
        send(3, d, sv, lat);
        n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL round_pos: got %0d want 2", $signed(d)); end
        n_cmp++; if (sv !== 1'b0) begin n_bad++; $display("FAIL round_pos_sat: got %b want 0", sv); end
        do_reset();
        write_coef(0, 16'h4000);
        send(-3, d, sv, lat);
        n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL round_neg: got %0d want -1", $signed(d)); end
        n_cmp++; if (sv !== 1'b0) begin n_bad++; $display("FAIL round_neg_sat: got %b want 0", sv); end
    endtask

    task automatic test_saturation();
        logic [31:0] d; logic sv; int lat;
        logic [31:0] exp_p [3];
        logic [31:0] exp_n [3];
        logic        exp_s [3];
        int          at [3];
        int          j;
        exp_p = '{32'h3FFF_0001, 32'h7FFE_0002, 32'h7FFF_FFFF};
        exp_n = '{32'hC000_8000, 32'h8001_0000, 32'h8000_0000};
        exp_s = '{1'b0, 1'b0, 1'b1};
        at    = '{0, 1, 99};
        sel = 2'd0;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int k = 0; k < 100; k++) write_coef(k, 16'h7FFF);
            j = 0;
            for (int n = 0; n < 100; n++) begin
                send((pass == 0) ? 32767 : -32768, d, sv, lat);
                if (n == at[j]) begin
                    n_cmp++;
                    if (d !== ((pass == 0) ? exp_p[j] : exp_n[j])) begin
                        n_bad++;
                        $display("FAIL sat_data p%0d[%0d]: got %h want %h", pass, n, d,
                                 (pass == 0) ? exp_p[j] : exp_n[j]);
                    end
                    n_cmp++;
                    if (sv !== exp_s[j]) begin
                        n_bad++;
                        $display("FAIL sat_flag p%0d[%0d]: got %b want %b", pass, n, sv, exp_s[j]);
                    end
                    if (j < 2) j++;
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic sv; int lat;
        sel = 2'd0;
        do_reset();
        write_coef(0, 5);
        write_coef(1, 2);
        out_ready = 1'b0;
        send(7, d, sv, lat);
        n_cmp++; if (d !== 32'd35) begin n_bad++; $display("FAIL bp_first: got %0d want 35", $signed(d)); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            data_in  = 16'sd99;
            @(negedge clk);
            n_cmp++; if (o_dout !== 32'd35) begin n_bad++; $display("FAIL bp_hold[%0d]: got %0d want 35", i, $signed(o_dout)); end
            n_cmp++; if (o_vld !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, o_vld); end
            n_cmp++; if (o_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, o_rdy); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", o_rdy); end
        n_cmp++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", o_vld); end
        // History must be [0, 7]; any accepted 99 would change this result.
        send(0, d, sv, lat);
        n_cmp++; if (d !== 32'd14) begin n_bad++; $display("FAIL bp_no_loss: got %0d want 14", $signed(d)); end
    endtask

    task automatic test_coef_protect();
        logic [31:0] d; logic sv; int lat;
        sel = 2'd0;
        do_reset();
        write_coef(0, 1);
        write_coef(1, 2);
        data_in = 16'sd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we = 1'b1; coef_addr = 7'd1; coef_wdata = 16'sd77;
        @(negedge clk);
        coef_we = 1'b0;
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL err_mac: got %b want 1", o_err); end
        @(negedge clk);
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse: got %b want 0", o_err); end
        wait_out(d, sv, lat);
        n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL prot_first: got %0d want 1", $signed(d)); end
        send(0, d, sv, lat);
        n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL prot_unchanged: got %0d want 2", $signed(d)); end
        @(negedge clk);
        write_coef(100, 55);
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL err_addr: got %b want 1", o_err); end
        write_coef(0, 3);
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL err_legal: got %b want 0", o_err); end
        data_in = 16'sd1; in_valid = 1'b1;
        coef_we = 1'b1; coef_addr = 7'd0; coef_wdata = 16'sd123;
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL err_simul: got %b want 0", o_err); end
        wait_out(d, sv, lat);
        n_cmp++; if (d !== 32'd123) begin n_bad++; $display("FAIL simul_write: got %0d want 123", $signed(d)); end
        n_cmp++; if (lat != 52) begin n_bad++; $display("FAIL simul_latency: got %0d want 52", lat); end
    endtask

    task automatic test_reset_mid_mac();
        logic [31:0] d; logic sv; int lat;
        sel = 2'd0;
        do_reset();
        write_coef(0, 9);
        write_coef(1, 4);
        write_coef(2, 3);
        send(5, d, sv, lat);
        n_cmp++; if (d !== 32'd45) begin n_bad++; $display("FAIL mid_pre: got %0d want 45", $signed(d)); end
        @(negedge clk);
        data_in = 16'sd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", o_vld); end
        n_cmp++; if (o_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", o_rdy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (o_rdy !== 1'b1) begin n_bad++; $display("FAIL mid_rel_ready: got %b want 1", o_rdy); end
        n_cmp++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL mid_rel_valid: got %b want 0", o_vld); end
        @(negedge clk);
        send(1, d, sv, lat);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL mid_coef_zero: got %0d want 0", $signed(d)); end
        @(negedge clk);
        write_coef(0, 9);
        write_coef(1, 4);
        write_coef(2, 3);
        // History is [0, 1, 0]: the discarded 6 must not survive the reset.
        send(0, d, sv, lat);
        n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL mid_history: got %0d want 4", $signed(d)); end
    endtask

    initial begin
        test_reset();
        test_impulse(2'd0, 50);
        test_impulse(2'd2, 100);
        test_impulse(2'd3, 25);
        test_rounding();
        test_saturation();
        test_backpressure();
        test_coef_protect();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
